// File: rtl/mem_pkg.sv
// Shared encodings for the fetch/data memory port arbiter.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mem_pkg;

    // funct3 load-type encodings
    localparam logic [2:0] LT_LB  = 3'b000;
    localparam logic [2:0] LT_LH  = 3'b001;
    localparam logic [2:0] LT_LW  = 3'b010;
    localparam logic [2:0] LT_LBU = 3'b100;
    localparam logic [2:0] LT_LHU = 3'b101;

    // Canonical no-op instruction word
    localparam logic [31:0] NOP_INSN = 32'h0000_0013;

    // Which requester owns the memory port this cycle
    typedef enum logic [1:0] {
        GNT_NONE   = 2'd0,
        GNT_IFETCH = 2'd1,
        GNT_DATA   = 2'd2
    } grant_e;

    // Load types that move a halfword
    function automatic logic is_half_load(input logic [2:0] lt);
        return (lt == LT_LH) || (lt == LT_LHU);
    endfunction

endpackage

// File: rtl/mem_port_arbiter_align.sv
// Misalignment detector for a data-port access (loads by load type, stores by byte enables).
// Latency: purely combinational.
// Backpressure: none; evaluated whenever the caller needs it.
module mem_align_check
    import mem_pkg::*;
(
    input  logic [2:0] load_type_i,
    input  logic [3:0] be_i,
    input  logic [1:0] addr_lo_i,
    input  logic       we_i,
    output logic       err_o
);

    logic half;
    logic word;
    logic bad_be;

    // Classify access size, then test the low address bits against it
    always_comb begin
        half   = 1'b0;
        word   = 1'b0;
        bad_be = 1'b0;
        if (we_i) begin
            unique case (be_i)
                4'b0001, 4'b0010, 4'b0100, 4'b1000: ;
                4'b0011, 4'b1100:                   half   = 1'b1;
                4'b1111:                            word   = 1'b1;
                // Straddling or non-contiguous lanes cannot be a legal aligned store
                default:                            bad_be = 1'b1;
            endcase
        end else begin
            half = is_half_load(load_type_i);
            word = (load_type_i == LT_LW);
        end
        err_o = bad_be || (half && addr_lo_i[0]) || (word && (addr_lo_i != 2'b00));
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and load/store; data wins unless fetch is starved.
// Latency: memory side combinational from the grant; responses registered, valid 1 cycle after accept.
// Backpressure: ready only for the granted requester, one accept per cycle; no response-side stall.
module mem_port_arbiter
    import mem_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_req_valid,
    output logic                  i_req_ready,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    input  logic                  i_flush,
    output logic                  i_resp_valid,
    output logic [DATA_WIDTH-1:0] i_resp_data,
    input  logic                  d_req_valid,
    output logic                  d_req_ready,
    input  logic [ADDR_WIDTH-1:0] d_addr,
    input  logic                  d_we,
    input  logic [DATA_WIDTH-1:0] d_wdata,
    input  logic [3:0]            d_be,
    input  logic [2:0]            d_load_type,
    output logic                  d_resp_valid,
    output logic [DATA_WIDTH-1:0] d_resp_data,
    output logic                  d_resp_err,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_re,
    output logic                  mem_we,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic [3:0]            mem_be,
    output logic [2:0]            mem_load_type,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

    localparam int             CW   = $clog2(STARVE_MAX + 1);
    localparam logic [CW-1:0]  SMAX = CW'(STARVE_MAX);

    grant_e                gnt_d;
    grant_e                grant_q;
    logic [CW-1:0]         starve_cnt_d;
    logic [CW-1:0]         starve_cnt_q;
    logic                  d_err;
    logic                  i_live_q;
    logic [DATA_WIDTH-1:0] i_data_q;
    logic [DATA_WIDTH-1:0] d_data_q;
    logic                  d_err_q;
    logic                  unused_addr_lo;

    // Fetch addresses are forced word-aligned, so the low bits are intentionally dropped
    assign unused_addr_lo = &{1'b0, i_addr[1:0]};

    mem_align_check u_align (
        .load_type_i (d_load_type),
        .be_i        (d_be),
        .addr_lo_i   (d_addr[1:0]),
        .we_i        (d_we),
        .err_o       (d_err)
    );

    // Pick this cycle's owner; nothing is granted while reset is held so all outputs stay quiet
    always_comb begin
        gnt_d = GNT_NONE;
        if (rst_n) begin
            if ((starve_cnt_q == SMAX) && i_req_valid) begin
                gnt_d = GNT_IFETCH;
            end else if (d_req_valid) begin
                gnt_d = GNT_DATA;
            end else if (i_req_valid) begin
                gnt_d = GNT_IFETCH;
            end
        end
    end

    assign i_req_ready = (gnt_d == GNT_IFETCH);
    assign d_req_ready = (gnt_d == GNT_DATA);

    // Count consecutive refused fetch cycles, saturating so the next chance goes to fetch
    always_comb begin
        starve_cnt_d = '0;
        if (i_req_valid && !i_req_ready) begin
            starve_cnt_d = (starve_cnt_q == SMAX) ? starve_cnt_q : starve_cnt_q + 1'b1;
        end
    end

    // Drive the memory port from the current grant; misaligned data accesses issue nothing
    always_comb begin
        mem_addr      = '0;
        mem_re        = 1'b0;
        mem_we        = 1'b0;
        mem_wdata     = '0;
        mem_be        = 4'b0000;
        mem_load_type = 3'b000;
        unique case (gnt_d)
            GNT_IFETCH: begin
                mem_addr      = {i_addr[ADDR_WIDTH-1:2], 2'b00};
                mem_re        = 1'b1;
                mem_be        = 4'b1111;
                mem_load_type = LT_LW;
            end
            GNT_DATA: begin
                mem_addr      = d_addr;
                mem_re        = !d_we && !d_err;
                mem_we        = d_we && !d_err;
                mem_wdata     = d_wdata;
                mem_be        = d_be;
                mem_load_type = d_load_type;
            end
            default: ;
        endcase
    end

    // Register grant, starvation count and responses; data registers hold when not refreshed
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grant_q      <= GNT_NONE;
            starve_cnt_q <= '0;
            i_live_q     <= 1'b0;
            i_data_q     <= '0;
            d_data_q     <= '0;
            d_err_q      <= 1'b0;
        end else begin
            grant_q      <= gnt_d;
            starve_cnt_q <= starve_cnt_d;
            // A flush in the acceptance cycle kills this fetch's response
            i_live_q     <= (gnt_d == GNT_IFETCH) && !i_flush;
            d_err_q      <= (gnt_d == GNT_DATA) && d_err;
            if (gnt_d == GNT_IFETCH) begin
                i_data_q <= mem_rdata;
            end
            if (gnt_d == GNT_DATA) begin
                d_data_q <= (d_err || d_we) ? '0 : mem_rdata;
            end
        end
    end

    // A flush in the response cycle also suppresses the fetch response
    assign i_resp_valid = i_live_q && !i_flush;
    assign i_resp_data  = i_data_q;
    assign d_resp_valid = (grant_q == GNT_DATA);
    assign d_resp_data  = d_data_q;
    assign d_resp_err   = d_err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter with a byte-addressed memory model.
// Latency: checks ready/memory side in the accept cycle and responses one cycle later.
// Backpressure: exercises data priority, fetch starvation, flush and mid-transaction reset.
module tb_mem_port_arbiter;

    logic        clk;
    logic        rst_n;
    logic        i_req_valid;
    logic        i_req_ready;
    logic [31:0] i_addr;
    logic        i_flush;
    logic        i_resp_valid;
    logic [31:0] i_resp_data;
    logic        d_req_valid;
    logic        d_req_ready;
    logic [31:0] d_addr;
    logic        d_we;
    logic [31:0] d_wdata;
    logic [3:0]  d_be;
    logic [2:0]  d_load_type;
    logic        d_resp_valid;
    logic [31:0] d_resp_data;
    logic        d_resp_err;
    logic [31:0] mem_addr;
    logic        mem_re;
    logic        mem_we;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic [2:0]  mem_load_type;
    logic [31:0] mem_rdata;

    int n_chk  = 0;
    int n_fail = 0;

    mem_port_arbiter #(
        .ADDR_WIDTH (32),
        .DATA_WIDTH (32),
        .STARVE_MAX (4)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_req_valid   (i_req_valid),
        .i_req_ready   (i_req_ready),
        .i_addr        (i_addr),
        .i_flush       (i_flush),
        .i_resp_valid  (i_resp_valid),
        .i_resp_data   (i_resp_data),
        .d_req_valid   (d_req_valid),
        .d_req_ready   (d_req_ready),
        .d_addr        (d_addr),
        .d_we          (d_we),
        .d_wdata       (d_wdata),
        .d_be          (d_be),
        .d_load_type   (d_load_type),
        .d_resp_valid  (d_resp_valid),
        .d_resp_data   (d_resp_data),
        .d_resp_err    (d_resp_err),
        .mem_addr      (mem_addr),
        .mem_re        (mem_re),
        .mem_we        (mem_we),
        .mem_wdata     (mem_wdata),
        .mem_be        (mem_be),
        .mem_load_type (mem_load_type),
        .mem_rdata     (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model: word k initialised to C0DE0000|k; extension done by load type
    logic [31:0] mem [0:4095];
    bit          init_done = 1'b0;
    logic [31:0] rd_w;
    logic [31:0] rd_sh;
    logic        tb_unused;
    assign tb_unused = &{1'b0, mem_addr[31:14], mem_re};

    always @(posedge clk) begin
        if (!init_done) begin
            for (int k = 0; k < 4096; k++) mem[k] <= 32'hC0DE_0000 | 32'(k);
            init_done <= 1'b1;
        end else if (mem_we) begin
            for (int b = 0; b < 4; b++)
                if (mem_be[b]) mem[mem_addr[13:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
        end
    end

    always_comb begin
        rd_w  = mem[mem_addr[13:2]];
        rd_sh = rd_w >> {mem_addr[1:0], 3'b000};
        case (mem_load_type)
            3'b000:  mem_rdata = {{24{rd_sh[7]}}, rd_sh[7:0]};
            3'b001:  mem_rdata = {{16{rd_sh[15]}}, rd_sh[15:0]};
            3'b100:  mem_rdata = {24'h0, rd_sh[7:0]};
            3'b101:  mem_rdata = {16'h0, rd_sh[15:0]};
            default: mem_rdata = rd_w;
        endcase
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic idle_inputs();
        i_req_valid = 1'b0; i_addr = 32'h0; i_flush = 1'b0;
        d_req_valid = 1'b0; d_addr = 32'h0; d_we = 1'b0;
        d_wdata = 32'h0; d_be = 4'h0; d_load_type = 3'b000;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, " i_req_ready"},   32'(i_req_ready),   32'h0);
        chk({tag, " d_req_ready"},   32'(d_req_ready),   32'h0);
        chk({tag, " i_resp_valid"},  32'(i_resp_valid),  32'h0);
        chk({tag, " i_resp_data"},   i_resp_data,        32'h0);
        chk({tag, " d_resp_valid"},  32'(d_resp_valid),  32'h0);
        chk({tag, " d_resp_data"},   d_resp_data,        32'h0);
        chk({tag, " d_resp_err"},    32'(d_resp_err),    32'h0);
        chk({tag, " mem_re"},        32'(mem_re),        32'h0);
        chk({tag, " mem_we"},        32'(mem_we),        32'h0);
        chk({tag, " mem_addr"},      mem_addr,           32'h0);
        chk({tag, " mem_wdata"},     mem_wdata,          32'h0);
        chk({tag, " mem_be"},        32'(mem_be),        32'h0);
        chk({tag, " mem_load_type"}, 32'(mem_load_type), 32'h0);
    endtask

    typedef struct {
        logic        i_vld;
        logic [31:0] i_a;
        logic        d_vld;
        logic [31:0] d_a;
        logic        we;
        logic [31:0] wd;
        logic [3:0]  be;
        logic [2:0]  lt;
        logic        x_irdy;
        logic        x_drdy;
        logic        x_re;
        logic        x_we;
        logic [31:0] x_maddr;
        logic        x_irv;
        logic [31:0] x_ird;
        logic        x_drv;
        logic [31:0] x_drd;
        logic        x_derr;
    } vec_t;

    vec_t vecs[12];

    initial begin
        int run;
        int max_run;
        logic exp_i;

        //          i_vld i_a          d_vld d_a          we   wd            be     lt      irdy drdy re   we   maddr        irv  ird           drv  drd           derr
        vecs[0]  = '{1'b0, 32'h0,      1'b0, 32'h0,      1'b0, 32'h0,        4'h0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,      1'b0, 32'h0,        1'b0, 32'h0,        1'b0};
        vecs[1]  = '{1'b1, 32'h100,    1'b0, 32'h0,      1'b0, 32'h0,        4'h0, 3'b000, 1'b1, 1'b0, 1'b1, 1'b0, 32'h100,    1'b1, 32'hC0DE0040, 1'b0, 32'h0,        1'b0};
        vecs[2]  = '{1'b1, 32'h106,    1'b0, 32'h0,      1'b0, 32'h0,        4'h0, 3'b000, 1'b1, 1'b0, 1'b1, 1'b0, 32'h104,    1'b1, 32'hC0DE0041, 1'b0, 32'h0,        1'b0};
        vecs[3]  = '{1'b0, 32'h0,      1'b1, 32'h2000,   1'b1, 32'hDEADBEEF, 4'hF, 3'b010, 1'b0, 1'b1, 1'b0, 1'b1, 32'h2000,   1'b0, 32'hC0DE0041, 1'b1, 32'h0,        1'b0};
        vecs[4]  = '{1'b0, 32'h0,      1'b1, 32'h2003,   1'b0, 32'h0,        4'h0, 3'b100, 1'b0, 1'b1, 1'b1, 1'b0, 32'h2003,   1'b0, 32'hC0DE0041, 1'b1, 32'h000000DE, 1'b0};
        vecs[5]  = '{1'b0, 32'h0,      1'b1, 32'h2003,   1'b0, 32'h0,        4'h0, 3'b000, 1'b0, 1'b1, 1'b1, 1'b0, 32'h2003,   1'b0, 32'hC0DE0041, 1'b1, 32'hFFFFFFDE, 1'b0};
        vecs[6]  = '{1'b0, 32'h0,      1'b1, 32'h2002,   1'b0, 32'h0,        4'h0, 3'b001, 1'b0, 1'b1, 1'b1, 1'b0, 32'h2002,   1'b0, 32'hC0DE0041, 1'b1, 32'hFFFFDEAD, 1'b0};
        vecs[7]  = '{1'b0, 32'h0,      1'b1, 32'h2002,   1'b0, 32'h0,        4'h0, 3'b010, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0,      1'b0, 32'hC0DE0041, 1'b1, 32'h0,        1'b1};
        vecs[8]  = '{1'b0, 32'h0,      1'b1, 32'h2001,   1'b1, 32'h00112200, 4'h6, 3'b001, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0,      1'b0, 32'hC0DE0041, 1'b1, 32'h0,        1'b1};
        vecs[9]  = '{1'b0, 32'h0,      1'b1, 32'h2001,   1'b0, 32'h0,        4'h0, 3'b101, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0,      1'b0, 32'hC0DE0041, 1'b1, 32'h0,        1'b1};
        vecs[10] = '{1'b1, 32'h200,    1'b1, 32'h2000,   1'b0, 32'h0,        4'h0, 3'b010, 1'b0, 1'b1, 1'b1, 1'b0, 32'h2000,   1'b0, 32'hC0DE0041, 1'b1, 32'hDEADBEEF, 1'b0};
        vecs[11] = '{1'b0, 32'h0,      1'b0, 32'h0,      1'b0, 32'h0,        4'h0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,      1'b0, 32'hC0DE0041, 1'b0, 32'hDEADBEEF, 1'b0};

        // Reset state
        rst_n = 1'b0;
        idle_inputs();
        repeat (3) @(posedge clk);
        #1 chk_all_zero("reset");
        @(negedge clk) rst_n = 1'b1;

        // Table-driven single-cycle transactions
        for (int v = 0; v < 12; v++) begin
            @(negedge clk);
            i_req_valid = vecs[v].i_vld; i_addr = vecs[v].i_a; i_flush = 1'b0;
            d_req_valid = vecs[v].d_vld; d_addr = vecs[v].d_a; d_we = vecs[v].we;
            d_wdata = vecs[v].wd; d_be = vecs[v].be; d_load_type = vecs[v].lt;
            #1;
            chk($sformatf("v%0d i_req_ready", v), 32'(i_req_ready), 32'(vecs[v].x_irdy));
            chk($sformatf("v%0d d_req_ready", v), 32'(d_req_ready), 32'(vecs[v].x_drdy));
            chk($sformatf("v%0d mem_re", v),      32'(mem_re),      32'(vecs[v].x_re));
            chk($sformatf("v%0d mem_we", v),      32'(mem_we),      32'(vecs[v].x_we));
            if (vecs[v].x_re || vecs[v].x_we)
                chk($sformatf("v%0d mem_addr", v), mem_addr, vecs[v].x_maddr);
            @(posedge clk);
            #1;
            chk($sformatf("v%0d i_resp_valid", v), 32'(i_resp_valid), 32'(vecs[v].x_irv));
            chk($sformatf("v%0d i_resp_data", v),  i_resp_data,       vecs[v].x_ird);
            chk($sformatf("v%0d d_resp_valid", v), 32'(d_resp_valid), 32'(vecs[v].x_drv));
            chk($sformatf("v%0d d_resp_data", v),  d_resp_data,       vecs[v].x_drd);
            chk($sformatf("v%0d d_resp_err", v),   32'(d_resp_err),   32'(vecs[v].x_derr));
        end

        // Both requesters held valid for 10 cycles: D,D,D,D,I repeating
        run = 0;
        max_run = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            i_req_valid = 1'b1; i_addr = 32'h300;
            d_req_valid = 1'b1; d_addr = 32'h2000; d_we = 1'b0; d_be = 4'h0; d_load_type = 3'b010;
            exp_i = ((c % 5) == 4);
            #1;
            chk($sformatf("starve c%0d i_req_ready", c), 32'(i_req_ready), 32'(exp_i));
            chk($sformatf("starve c%0d d_req_ready", c), 32'(d_req_ready), 32'(!exp_i));
            if (i_req_ready) run = 0;
            else run++;
            if (run > max_run) max_run = run;
            @(posedge clk);
            #1;
            chk($sformatf("starve c%0d i_resp_valid", c), 32'(i_resp_valid), 32'(exp_i));
            if (exp_i) chk($sformatf("starve c%0d i_resp_data", c), i_resp_data, 32'hC0DE00C0);
        end
        chk("starve longest refusal run <= 4", 32'(max_run <= 4), 32'h1);

        // Flush: after accept kills the response; in the accept cycle kills that fetch; next one is normal
        @(negedge clk);
        idle_inputs();
        i_req_valid = 1'b1; i_addr = 32'h100;
        #1 chk("flush f0 i_req_ready", 32'(i_req_ready), 32'h1);
        @(negedge clk);
        i_addr = 32'h104; i_flush = 1'b1;
        #1;
        chk("flush f0 i_resp_valid", 32'(i_resp_valid), 32'h0);
        chk("flush f1 i_req_ready",  32'(i_req_ready),  32'h1);
        @(negedge clk);
        i_addr = 32'h108; i_flush = 1'b0;
        #1;
        chk("flush f1 i_resp_valid", 32'(i_resp_valid), 32'h0);
        chk("flush f2 i_req_ready",  32'(i_req_ready),  32'h1);
        @(negedge clk);
        idle_inputs();
        #1;
        chk("flush f2 i_resp_valid", 32'(i_resp_valid), 32'h1);
        chk("flush f2 i_resp_data",  i_resp_data,       32'hC0DE0042);

        // Reset right after a load is accepted: response is dropped and never reappears
        @(negedge clk);
        d_req_valid = 1'b1; d_addr = 32'h2000; d_load_type = 3'b010;
        #1 chk("rst load d_req_ready", 32'(d_req_ready), 32'h1);
        @(posedge clk);
        #1 rst_n = 1'b0;
        i_req_valid = 1'b1; i_addr = 32'h100;
        #1 chk_all_zero("in-reset");
        @(negedge clk);
        rst_n = 1'b1;
        idle_inputs();
        for (int c = 0; c < 3; c++) begin
            @(posedge clk);
            #1 chk($sformatf("post-reset c%0d d_resp_valid", c), 32'(d_resp_valid), 32'h0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-port, byte-addressed memory port between the instruction-fetch requester and the load/store requester.
- Sits between the core's fetch and memory stages and the unified memory's data port.
- Uses valid/ready request handshakes with registered responses; data has priority, and a starvation counter guarantees fetch progress.
- Flags misaligned data accesses with an error response instead of issuing them.

Parameters:
- ADDR_WIDTH, 32, address width.
- DATA_WIDTH, 32, data width.
- STARVE_MAX, 4, consecutive cycles fetch may be refused while valid before it wins arbitration.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- i_req_valid  in  1  fetch request valid.
- i_req_ready  out  1  fetch request accepted this cycle.
- i_addr  in  ADDR_WIDTH  fetch address; bits [1:0] ignored.
- i_flush  in  1  discard any fetch response due next cycle.
- i_resp_valid  out  1  fetch response valid.
- i_resp_data  out  DATA_WIDTH  fetched word.
- d_req_valid  in  1  data request valid.
- d_req_ready  out  1  data request accepted this cycle.
- d_addr  in  ADDR_WIDTH  byte address.
- d_we  in  1  1 = store, 0 = load.
- d_wdata  in  DATA_WIDTH  store data, already lane-aligned.
- d_be  in  4  store byte enables.
- d_load_type  in  3  funct3 load type (000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU).
- d_resp_valid  out  1  data response valid (load data or store ack).
- d_resp_data  out  DATA_WIDTH  load result; 0 for stores and errors.
- d_resp_err  out  1  misaligned access; nothing was issued to memory.
- mem_addr  out  ADDR_WIDTH  memory address (fetch addresses word-aligned).
- mem_re  out  1  memory read enable.
- mem_we  out  1  memory write enable.
- mem_wdata  out  DATA_WIDTH  memory write data.
- mem_be  out  4  memory byte enables.
- mem_load_type  out  3  memory load type; 010 for fetches.
- mem_rdata  in  DATA_WIDTH  combinational read data for the current mem_addr.

Behaviour:
- Reset: all resp_valid outputs, d_resp_err, mem_re and mem_we are 0; all data outputs are 0; starvation counter is 0; grant register is NONE.
- Memory-side outputs are combinational from the current grant. Responses are registered.
- Arbitration each cycle, between valid requesters only:
  - if starve_cnt == STARVE_MAX and i_req_valid, grant fetch;
  - else if d_req_valid, grant data;
  - else if i_req_valid, grant fetch.
- ready is asserted only for the granted requester. At most one transaction is accepted per cycle.
- Requesters hold address and attributes stable while valid and not ready.
- Starvation counter:
  - increments (saturating at STARVE_MAX) when i_req_valid && !i_req_ready;
  - clears when a fetch is accepted or i_req_valid is low.
- Misalignment check on a granted data request: halfword with addr[0] set, or word with addr[1:0] != 0.
  - Loads use d_load_type; stores use d_be (0011 or 1100 = halfword, 1111 = word).
  - Misaligned: accept it (ready = 1), drive mem_re = mem_we = 0, and return d_resp_valid = 1, d_resp_err = 1, data 0 next cycle.
- Latency: response valid exactly 1 cycle after acceptance.
  - Read data is rdata sampled in the acceptance cycle.
  - Stores return a valid ack with data 0 after mem_we has been driven for one cycle.
- i_flush:
  - if high in the acceptance cycle or the following cycle, i_resp_valid is suppressed for that fetch;
  - does not block a new fetch in the same cycle; a fetch accepted in the flush cycle is itself discarded.
- Idle cycles: resp_valid outputs are 0 and resp_data holds its last value.
- Reset asserted mid-transaction: any pending response is dropped; no response after reset release.
- Stores never touch the fetch path. Write-to-read ordering is memory-defined; the arbiter never reorders.

Decomposition:
- Shared package mem_pkg holds:
  - load-type encodings (LB, LH, LW, LBU, LHU);
  - grant encoding NONE/IFETCH/DATA;
  - the NOP constant 32'h00000013.
- One sub-module, mem_align_check: combinational misalignment detector taking load_type/be/addr/we and producing err.
- Everything else lives in the top module.

Test Plan:
- Both requesters idle out of reset, then i_req_valid with i_addr = 0x100 -> i_req_ready = 1 that cycle; i_resp_valid = 1 next cycle with data equal to memory word 0x100.
- d_req_valid and i_req_valid asserted together for 10 cycles, STARVE_MAX = 4 -> grant pattern D,D,D,D,I repeating; fetch is never refused more than 4 cycles in a row.
- SW 0xDEADBEEF to 0x2000, then LBU at 0x2003 -> store ack with data 0; load returns 0x000000DE; LB at 0x2003 returns 0xFFFFFFDE.
- LW at 0x2002 -> d_resp_err = 1, data 0, mem_re = mem_we = 0 during acceptance; an SH with be = 0110 is also flagged as an error.
- Fetch accepted, i_flush pulsed the next cycle -> no i_resp_valid; a fetch accepted after the flush responds normally.
- rst_n pulsed low on the cycle after a load is accepted -> no d_resp_valid ever appears; all outputs read 0 during reset.
